// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer tone generator: note table, command fields, states.
package buzz_pkg;

    localparam int unsigned NOTE_MSB = 7;
    localparam int unsigned NOTE_LSB = 4;
    localparam int unsigned DUR_MSB  = 3;
    localparam int unsigned DUR_LSB  = 0;
    localparam int unsigned HP_W     = 16;

    // Half-period in 50 MHz cycles, round(25e6/f); index 0 is the rest slot
    localparam logic [HP_W-1:0] NOTE_HP [0:15] = '{
        16'd0,     16'd47778, 16'd45097, 16'd42566,
        16'd40177, 16'd37922, 16'd35793, 16'd33784,
        16'd31888, 16'd30098, 16'd28409, 16'd26815,
        16'd25310, 16'd23889, 16'd22548, 16'd21283
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Scaled half-period, never below one cycle so the toggle logic always advances
    function automatic logic [HP_W-1:0] note_hp(input logic [3:0] idx, input int unsigned shift);
        logic [HP_W-1:0] hp;
        hp = NOTE_HP[idx] >> shift;
        if (hp == '0) begin
            hp = HP_W'(1);
        end
        return hp;
    endfunction

endpackage

// File: rtl/buzz_tone_gen_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles; clear restarts the count.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign tick_c = (cnt == LAST);

endmodule

// File: rtl/buzz_tone_gen.sv
// Buzzer tone generator: plays note/duration commands with a one-deep pending slot.
// Define BUZZ_GAP_EN to insert GAP_TICKS of silence after every note.
module buzz_tone_gen
    import buzz_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned UNIT_TICKS = 50,
    parameter int unsigned GAP_TICKS  = 10,
    parameter int unsigned NOTE_SHIFT = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       Buzz
);

    localparam int unsigned DW = $clog2(15 * UNIT_TICKS + 1);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_PLAY = 2'(PLAY);
`ifdef BUZZ_GAP_EN
    localparam logic [1:0] ST_GAP  = 2'(GAP);
`endif

    // The gap reuses the duration counter, so its length must fit there
    if (TICK_DIV == 0 || UNIT_TICKS == 0 || GAP_TICKS > 15 * UNIT_TICKS) begin : g_bad_cfg
        $error("buzz_tone_gen: unsupported TICK_DIV/UNIT_TICKS/GAP_TICKS");
    end
`ifdef BUZZ_GAP_EN
    if (GAP_TICKS == 0) begin : g_bad_gap
        $error("buzz_tone_gen: GAP_TICKS must be nonzero with the gap enabled");
    end
`endif

    logic [1:0]      state, state_nx;
    logic            pend_vld, pend_vld_nx;
    logic [7:0]      pend_cmd, pend_cmd_nx;
    logic [DW-1:0]   dur_cnt, dur_nx;
    logic [DW-1:0]   dur_last, dur_last_nx;
    logic [HP_W-1:0] hp, hp_nx;
    logic [HP_W-1:0] hp_cnt, hp_cnt_nx;
    logic            rest, rest_nx;
    logic            buzz_nx, done_nx, busy_nx;
    logic            clear_c, tick_c;
    logic            take_next, load;
    logic [7:0]      load_cmd;
    logic            wr_cmd, wr_abort;

    assign wr_cmd   = wr && (din[DUR_MSB:DUR_LSB] != 4'd0);
    assign wr_abort = wr && (din[DUR_MSB:DUR_LSB] == 4'd0);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (clear_c),
        .tick_c (tick_c)
    );

    // Next-state and output decode
    always_comb begin
        state_nx    = state;
        pend_vld_nx = pend_vld;
        pend_cmd_nx = pend_cmd;
        dur_nx      = dur_cnt;
        dur_last_nx = dur_last;
        hp_nx       = hp;
        hp_cnt_nx   = hp_cnt;
        rest_nx     = rest;
        buzz_nx     = Buzz;
        done_nx     = 1'b0;
        clear_c     = 1'b0;
        take_next   = 1'b0;
        load        = 1'b0;
        load_cmd    = pend_cmd;

        case (state)
            ST_IDLE: begin
                clear_c   = 1'b1;
                buzz_nx   = 1'b0;
                take_next = 1'b1;
            end
            ST_PLAY: begin
                if (wr_cmd) begin
                    pend_vld_nx = 1'b1;
                    pend_cmd_nx = din;
                end
                if (tick_c && (dur_cnt == dur_last)) begin
                    buzz_nx = 1'b0;
                    done_nx = 1'b1;
                    dur_nx  = '0;
`ifdef BUZZ_GAP_EN
                    state_nx    = ST_GAP;
                    dur_last_nx = DW'(GAP_TICKS - 1);
`else
                    state_nx    = ST_IDLE;
`endif
                end else begin
                    if (tick_c) begin
                        dur_nx = dur_cnt + DW'(1);
                    end
                    if (hp_cnt == hp - HP_W'(1)) begin
                        hp_cnt_nx = '0;
                        buzz_nx   = !rest && !Buzz;
                    end else begin
                        hp_cnt_nx = hp_cnt + HP_W'(1);
                    end
                end
            end
`ifdef BUZZ_GAP_EN
            ST_GAP: begin
                buzz_nx = 1'b0;
                if (wr_cmd) begin
                    pend_vld_nx = 1'b1;
                    pend_cmd_nx = din;
                end
                if (tick_c) begin
                    if (dur_cnt == dur_last) begin
                        take_next = 1'b1;
                    end else begin
                        dur_nx = dur_cnt + DW'(1);
                    end
                end
            end
`endif
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Pending slot wins; a same-cycle write then refills it
        if (take_next) begin
            if (pend_vld) begin
                load        = 1'b1;
                load_cmd    = pend_cmd;
                pend_vld_nx = wr_cmd;
                pend_cmd_nx = wr_cmd ? din : pend_cmd;
            end else if (wr_cmd) begin
                load        = 1'b1;
                load_cmd    = din;
                pend_vld_nx = 1'b0;
            end else begin
                state_nx = ST_IDLE;
            end
        end

        if (load) begin
            state_nx    = ST_PLAY;
            clear_c     = 1'b1;
            dur_nx      = '0;
            dur_last_nx = DW'(32'(load_cmd[DUR_MSB:DUR_LSB]) * UNIT_TICKS - 32'd1);
            hp_nx       = note_hp(load_cmd[NOTE_MSB:NOTE_LSB], NOTE_SHIFT);
            hp_cnt_nx   = '0;
            rest_nx     = (load_cmd[NOTE_MSB:NOTE_LSB] == 4'd0);
            buzz_nx     = (load_cmd[NOTE_MSB:NOTE_LSB] != 4'd0);
        end

        if (wr_abort) begin
            state_nx    = ST_IDLE;
            pend_vld_nx = 1'b0;
            buzz_nx     = 1'b0;
            done_nx     = 1'b0;
            clear_c     = 1'b1;
            dur_nx      = '0;
            hp_cnt_nx   = '0;
        end

        busy_nx = (state_nx != ST_IDLE) || pend_vld_nx;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            pend_vld <= 1'b0;
            pend_cmd <= '0;
            dur_cnt  <= '0;
            dur_last <= '0;
            hp       <= HP_W'(1);
            hp_cnt   <= '0;
            rest     <= 1'b1;
            Buzz     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            pend_vld <= pend_vld_nx;
            pend_cmd <= pend_cmd_nx;
            dur_cnt  <= dur_nx;
            dur_last <= dur_last_nx;
            hp       <= hp_nx;
            hp_cnt   <= hp_cnt_nx;
            rest     <= rest_nx;
            Buzz     <= buzz_nx;
            done     <= done_nx;
            busy     <= busy_nx;
        end
    end

endmodule
